// File: rtl/score_ctrl_if.sv
// Score controller bus: game event pulses in, BCD digits and status out.
interface score_ctrl_if;
  logic       start;
  logic       score_inc;
  logic       bird_dead;
  logic       frame_tick;
  logic [3:0] number_0;
  logic [3:0] number_1;
  logic [3:0] number_2;
  logic [3:0] number_3;
  logic [3:0] highest_0;
  logic [3:0] highest_1;
  logic [3:0] highest_2;
  logic [3:0] highest_3;
  logic       disp_valid;
  logic       new_record;
  logic [1:0] game_state;

  // Game logic side: produces the event pulses, consumes the display data.
  modport master (
    output start, score_inc, bird_dead, frame_tick,
    input  number_0, number_1, number_2, number_3,
    input  highest_0, highest_1, highest_2, highest_3,
    input  disp_valid, new_record, game_state
  );

  // Score controller side.
  modport slave (
    input  start, score_inc, bird_dead, frame_tick,
    output number_0, number_1, number_2, number_3,
    output highest_0, highest_1, highest_2, highest_3,
    output disp_valid, new_record, game_state
  );
endinterface

// File: rtl/score_ctrl.sv
// Score controller: BCD score counting, digit-serial high-score compare,
// and new-record blink of the digit display.
module score_ctrl #(
  parameter int BLINK_PERIOD = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  score_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    CMP  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

  state_t          state_reg, state_next;
  // Index 0 is the most significant digit, index 3 the units digit.
  logic [3:0]      num_reg  [4];
  logic [3:0]      num_next [4];
  logic [3:0]      high_reg [4];
  logic [3:0]      high_next[4];
  logic [3:0]      num_inc  [4];
  logic            sat;
  logic [1:0]      idx_reg, idx_next;
  logic            nr_reg, nr_next;
  logic            dv_reg, dv_next;
  logic [BW-1:0]   blink_reg, blink_next;

  // BCD +1 with ripple carry from the units digit; sat stays high when every
  // digit is 9, in which case the score must not wrap.
  always_comb begin
    sat = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      num_inc[i] = num_reg[i];
      if (sat) begin
        if (num_reg[i] == 4'd9) begin
          num_inc[i] = 4'd0;
        end else begin
          num_inc[i] = num_reg[i] + 4'd1;
          sat        = 1'b0;
        end
      end
    end
    if (sat) num_inc = num_reg;
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_next = state_reg;
    num_next   = num_reg;
    high_next  = high_reg;
    idx_next   = idx_reg;
    nr_next    = nr_reg;
    dv_next    = dv_reg;
    blink_next = blink_reg;
    case (state_reg)
      IDLE: begin
        dv_next = 1'b1;
        if (bus.start) begin
          state_next = PLAY;
          num_next   = '{default: 4'd0};
          nr_next    = 1'b0;
        end
      end
      PLAY: begin
        dv_next = 1'b1;
        if (bus.score_inc) num_next = num_inc;
        if (bus.bird_dead) begin
          state_next = CMP;
          idx_next   = 2'd0;
        end
      end
      CMP: begin
        dv_next = 1'b1;
        if (num_reg[idx_reg] > high_reg[idx_reg]) begin
          state_next = OVER;
          high_next  = num_reg;
          nr_next    = 1'b1;
          blink_next = '0;
        end else if (num_reg[idx_reg] < high_reg[idx_reg] || idx_reg == 2'd3) begin
          state_next = OVER;
          blink_next = '0;
        end else begin
          idx_next = idx_reg + 2'd1;
        end
      end
      OVER: begin
        if (bus.start) begin
          state_next = PLAY;
          num_next   = '{default: 4'd0};
          nr_next    = 1'b0;
          dv_next    = 1'b1;
          blink_next = '0;
        end else if (nr_reg && bus.frame_tick) begin
          if (blink_reg == BLINK_LAST) begin
            blink_next = '0;
            dv_next    = ~dv_reg;
          end else begin
            blink_next = blink_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      num_reg   <= '{default: 4'd0};
      high_reg  <= '{default: 4'd0};
      idx_reg   <= 2'd0;
      nr_reg    <= 1'b0;
      dv_reg    <= 1'b1;
      blink_reg <= '0;
    end else begin
      state_reg <= state_next;
      num_reg   <= num_next;
      high_reg  <= high_next;
      idx_reg   <= idx_next;
      nr_reg    <= nr_next;
      dv_reg    <= dv_next;
      blink_reg <= blink_next;
    end
  end

  assign bus.number_0   = num_reg[0];
  assign bus.number_1   = num_reg[1];
  assign bus.number_2   = num_reg[2];
  assign bus.number_3   = num_reg[3];
  assign bus.highest_0  = high_reg[0];
  assign bus.highest_1  = high_reg[1];
  assign bus.highest_2  = high_reg[2];
  assign bus.highest_3  = high_reg[3];
  assign bus.disp_valid = dv_reg;
  assign bus.new_record = nr_reg;
  assign bus.game_state = state_reg;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with a short blink period.
module tb_score_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   ncmp;

  score_ctrl_if bus ();

  score_ctrl #(.BLINK_PERIOD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] score();
    return {bus.number_0, bus.number_1, bus.number_2, bus.number_3};
  endfunction

  function automatic logic [15:0] high();
    return {bus.highest_0, bus.highest_1, bus.highest_2, bus.highest_3};
  endfunction

  task automatic p_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic p_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.score_inc = 1'b1; tick(); bus.score_inc = 1'b0;
    end
  endtask

  task automatic p_dead();
    bus.bird_dead = 1'b1; tick(); bus.bird_dead = 1'b0;
  endtask

  task automatic p_frame(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1; tick(); bus.frame_tick = 1'b0;
    end
  endtask

  // Counts cycles spent in CMP after the bird_dead edge, bounded.
  task automatic wait_cmp(output int n);
    n = 0;
    while (bus.game_state == 2'd2 && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.score_inc = 1'b0; bus.bird_dead = 1'b0; bus.frame_tick = 1'b0;
    tick(); tick();
    chk("rst_state", 16'(bus.game_state), 16'd0);
    chk("rst_score", score(), 16'h0000);
    chk("rst_high", high(), 16'h0000);
    chk("rst_dv", 16'(bus.disp_valid), 16'd1);
    chk("rst_nr", 16'(bus.new_record), 16'd0);
    rst_n = 1'b1;

    p_inc(1);
    chk("idle_inc_ignored", score(), 16'h0000);
    p_start();
    chk("start_state", 16'(bus.game_state), 16'd1);
    p_inc(3);
    chk("score_3", score(), 16'h0003);
    chk("play_state", 16'(bus.game_state), 16'd1);
    p_inc(96);
    chk("score_99", score(), 16'h0099);
    p_inc(1);
    chk("carry_100", score(), 16'h0100);

    // First game sets high score 0120 against 0000: two CMP cycles.
    p_inc(20);
    chk("score_120", score(), 16'h0120);
    p_dead();
    chk("cmp_state", 16'(bus.game_state), 16'd2);
    wait_cmp(ncmp);
    chk("cmp_len_g1", 16'(ncmp), 16'd2);
    chk("high_120", high(), 16'h0120);
    chk("nr_g1", 16'(bus.new_record), 16'd1);

    // Second game ends at 0125 against 0120: differs only in units.
    p_start();
    chk("restart_score", score(), 16'h0000);
    chk("restart_nr", 16'(bus.new_record), 16'd0);
    chk("restart_high", high(), 16'h0120);
    p_inc(125);
    p_dead();
    wait_cmp(ncmp);
    chk("cmp_len_4", 16'(ncmp), 16'd4);
    chk("high_125", high(), 16'h0125);
    chk("nr_125", 16'(bus.new_record), 16'd1);
    chk("over_state", 16'(bus.game_state), 16'd3);
    chk("blink_t0", 16'(bus.disp_valid), 16'd1);
    p_frame(1);
    chk("blink_t1", 16'(bus.disp_valid), 16'd1);
    p_frame(1);
    chk("blink_t2", 16'(bus.disp_valid), 16'd0);
    p_frame(2);
    chk("blink_t4", 16'(bus.disp_valid), 16'd1);
    p_frame(3);
    chk("blink_t7", 16'(bus.disp_valid), 16'd0);

    // Reset mid-blink.
    rst_n = 1'b0; bus.frame_tick = 1'b1; bus.start = 1'b1;
    tick();
    rst_n = 1'b1; bus.frame_tick = 1'b0; bus.start = 1'b0;
    chk("midblink_rst_state", 16'(bus.game_state), 16'd0);
    chk("midblink_rst_dv", 16'(bus.disp_valid), 16'd1);
    chk("midblink_rst_score", score(), 16'h0000);
    chk("midblink_rst_high", high(), 16'h0000);

    // High score 0500, then a game at 0125 loses at the hundreds digit.
    p_start();
    p_inc(500);
    p_dead();
    wait_cmp(ncmp);
    chk("high_500", high(), 16'h0500);
    p_start();
    p_inc(125);
    p_dead();
    wait_cmp(ncmp);
    chk("cmp_len_2", 16'(ncmp), 16'd2);
    chk("high_kept_500", high(), 16'h0500);
    chk("nr_0", 16'(bus.new_record), 16'd0);
    p_frame(4);
    chk("dv_held", 16'(bus.disp_valid), 16'd1);

    // Simultaneous increment and death at 0009, start ignored in CMP.
    p_start();
    p_inc(9);
    bus.score_inc = 1'b1; bus.bird_dead = 1'b1;
    tick();
    bus.score_inc = 1'b0; bus.bird_dead = 1'b0;
    chk("inc_dead_state", 16'(bus.game_state), 16'd2);
    chk("inc_dead_score", score(), 16'h0010);
    p_start();
    chk("cmp_start_ignored", 16'(bus.game_state), 16'd2);
    tick();
    chk("cmp_0010_over", 16'(bus.game_state), 16'd3);
    chk("cmp_0010_score", score(), 16'h0010);
    p_inc(1);
    chk("over_inc_ignored", score(), 16'h0010);

    // Saturation at 9999 and start ignored in PLAY.
    p_start();
    p_inc(9999);
    chk("score_9999", score(), 16'h9999);
    p_inc(1);
    chk("sat_9999", score(), 16'h9999);
    p_start();
    chk("play_start_ignored", score(), 16'h9999);
    p_dead();
    wait_cmp(ncmp);
    chk("cmp_len_1", 16'(ncmp), 16'd1);
    chk("high_9999", high(), 16'h9999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 SHALL have parameter BLINK_PERIOD, default 30, number of frame_tick pulses per half-period of the new-record blink.
REQ-002 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a game.
REQ-005 SHALL have port score_inc  input  1  single-cycle pulse meaning the bird passed one pipe.
REQ-006 SHALL have port bird_dead  input  1  single-cycle pulse meaning the game ended.
REQ-007 SHALL have port frame_tick  input  1  single-cycle pulse, once per video frame.
REQ-008 SHALL have ports number_0..number_3  output  4 each  current score as BCD, number_0 = thousands (leftmost digit), number_3 = units.
REQ-009 SHALL have ports highest_0..highest_3  output  4 each  high score as BCD, same digit order.
REQ-010 SHALL have port disp_valid  output  1  enable for the digit renderer.
REQ-011 SHALL have port new_record  output  1  high when the last finished game set a new high score.
REQ-012 SHALL have port game_state  output  2  encoding IDLE=0, PLAY=1, CMP=2, OVER=3.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, PLAY, CMP, OVER.
REQ-014 SHALL go from IDLE to PLAY on start, clearing the score to 0000 and new_record to 0 on the same edge.
REQ-015 SHALL, in PLAY, increment the score by one in BCD on each score_inc, with the new value visible one cycle after the pulse.
REQ-016 SHALL propagate carries: a digit at 9 becomes 0 and carries into the next more significant digit, all in the same cycle.
REQ-017 SHALL saturate the score at 9999; score_inc at 9999 leaves it unchanged.
REQ-018 SHALL ignore score_inc in IDLE, CMP and OVER.
REQ-019 SHALL ignore start in PLAY and CMP.
REQ-020 SHALL go from PLAY to CMP on bird_dead.
REQ-021 SHALL, when score_inc and bird_dead arrive in the same cycle, apply the increment and then enter CMP.
REQ-022 SHALL, in CMP, compare the score to the high score one digit per cycle, starting at index 0 (MSD) and using a 2-bit digit index.
REQ-023 SHALL resolve each CMP step as follows:
- score digit > high digit: decide "record", leave CMP.
- score digit < high digit: decide "no record", leave CMP.
- digits equal: advance the index; if all 4 digits are equal, decide "no record".
REQ-024 SHALL, on a "record" decision, copy number_0..3 into highest_0..3 and set new_record=1 on the same edge that enters OVER.
REQ-025 SHALL spend 1 to 4 cycles in CMP: 1 cycle if the digits differ at the MSD, 4 cycles if they equal the high score or differ only in the units digit.
REQ-026 SHALL go from OVER to PLAY on start, clearing the score and new_record and keeping highest_*.
REQ-027 SHALL drive disp_valid=1 in IDLE, PLAY and CMP.
REQ-028 SHALL, in OVER with new_record=0, hold disp_valid=1.
REQ-029 SHALL, in OVER with new_record=1, toggle disp_valid every BLINK_PERIOD frame_ticks, starting at 1 when OVER is entered.
REQ-030 SHALL use a blink counter wide enough for BLINK_PERIOD, cleared whenever OVER is entered.
REQ-031 SHALL register all outputs; no output has a combinational path from any input.
REQ-032 SHALL never produce a BCD digit value above 9 on any output.

Reset
REQ-033 SHALL, while rst_n=0 at a rising clk edge, set:
- state to IDLE;
- number_* and highest_* to 0;
- new_record to 0, disp_valid to 1, blink counter and CMP index to 0.
REQ-034 SHALL let reset asserted in any state, including mid-CMP and mid-blink, override every other input on that edge.
REQ-035 SHALL not retain the high score across reset.

Verification
REQ-036 Reset, start, 3× score_inc pulses -> number_0..3 = 0,0,0,3 one cycle after the last pulse; game_state=1.
REQ-037 Score 0099 plus one score_inc -> score 0100 next cycle; score 9999 plus one score_inc -> score stays 9999.
REQ-038 High score 0120, game ends at 0125 -> CMP lasts 4 cycles, then highest=0125, new_record=1, game_state=3.
REQ-039 High score 0500, game ends at 0125 -> CMP lasts 2 cycles, highest unchanged, new_record=0, disp_valid held 1.
REQ-040 With new_record=1 in OVER and BLINK_PERIOD=2, 4 frame_ticks -> disp_valid reads 1,0,1 after ticks 0,2,4; rst_n=0 mid-blink -> IDLE, disp_valid=1, all digits 0.
REQ-041 score_inc and bird_dead in the same cycle at score 0009 -> CMP evaluates 0010; a start pulse during CMP is ignored.
